q3_resp_checker: RTL and testbench

Synthesizable response checker on the receiving end of the q3 stimulus sweep. It accepts each applied 4-bit input vector together with the gate-level outputs and the UDP-model outputs, and compares them. It counts mismatches, records the first failing vector, and checks that vectors arrive as the expected in-order sweep. It sits beside the q3 gate/UDP instances and reports a single pass/fail verdict when the sweep completes.

---
 rtl/q3_resp_checker_if.sv | 30 +++
 rtl/q3_resp_checker.sv | 112 +++++++++++
 tb/tb_q3_resp_checker.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/q3_resp_checker_if.sv
// Stimulus/result bundle between the q3 sweep driver and q3_resp_checker.
// The driver uses the master modport and the checker uses the slave modport.
interface q3_resp_checker_if #(
  parameter int W_OUT = 2,
  parameter int CNT_W = 5
);
  logic             start;
  logic             vec_valid;
  logic [3:0]       vec;
  logic [W_OUT-1:0] dut_out;
  logic [W_OUT-1:0] ref_out;

  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [3:0]       first_fail_vec;
  logic [W_OUT-1:0] first_fail_mask;
  logic             seq_err;

  modport master (
    output start, vec_valid, vec, dut_out, ref_out,
    input  busy, done, pass, err_count, first_fail_vec, first_fail_mask, seq_err
  );

  modport slave (
    input  start, vec_valid, vec, dut_out, ref_out,
    output busy, done, pass, err_count, first_fail_vec, first_fail_mask, seq_err
  );
endinterface

// File: rtl/q3_resp_checker.sv
// Compares q3 gate-level outputs against the UDP model over an in-order vector sweep.
// Define Q3_CHK_HALT_ON_FAIL_EN to end the sweep at the first mismatching vector.
module q3_resp_checker #(
  parameter int W_OUT   = 2,
  parameter int NUM_VEC = 16,
  parameter int CNT_W   = 5
) (
  input logic              clk,
  input logic              rst,
  q3_resp_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

  state_t           state;
  logic [3:0]       exp_idx;

  logic             mismatch;
  logic             out_of_order;
  logic             finish;
  logic [CNT_W-1:0] err_next;
  logic             seq_next;

  always_comb begin
    // NOTE: !== makes an X/Z on either side count as a mismatch in simulation;
    // synthesis treats it as a plain inequality.
    mismatch     = (bus.dut_out !== bus.ref_out);
    out_of_order = (bus.vec != exp_idx);
    seq_next     = bus.seq_err | out_of_order;

    err_next = bus.err_count;
    if (mismatch && (bus.err_count != {CNT_W{1'b1}})) begin
      err_next = bus.err_count + 1'b1;
    end

`ifdef Q3_CHK_HALT_ON_FAIL_EN
    finish = (exp_idx == LAST_IDX) || mismatch;
`else
    finish = (exp_idx == LAST_IDX);
`endif
  end

  // NOTE: the reset is synchronous and every register here is a plain flop,
  // so all of them are cleared in the reset branch; sequential state uses
  // non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      exp_idx             <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.pass            <= 1'b0;
      bus.err_count       <= '0;
      bus.first_fail_vec  <= '0;
      bus.first_fail_mask <= '0;
      bus.seq_err         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Any vector presented alongside start is discarded.
          if (bus.start) begin
            state               <= RUN;
            exp_idx             <= '0;
            bus.busy            <= 1'b1;
            bus.done            <= 1'b0;
            bus.pass            <= 1'b0;
            bus.err_count       <= '0;
            bus.first_fail_vec  <= '0;
            bus.first_fail_mask <= '0;
            bus.seq_err         <= 1'b0;
          end
        end

        RUN: begin
          if (bus.vec_valid) begin
            bus.err_count <= err_next;
            bus.seq_err   <= seq_next;
            exp_idx       <= exp_idx + 4'd1;

            // A zero count means no mismatch has been seen this sweep;
            // saturation never wraps it back to zero.
            if (mismatch && (bus.err_count == '0)) begin
              bus.first_fail_vec  <= bus.vec;
              bus.first_fail_mask <= bus.dut_out ^ bus.ref_out;
            end

            if (finish) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (err_next == '0) && !seq_next;
            end
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          bus.pass <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q3_resp_checker.sv
// Randomized scoreboard bench for q3_resp_checker: two instances (CNT_W=5 and CNT_W=2)
// share one stimulus stream; a monitor compares both against a per-cycle expected queue.
module tb_q3_resp_checker;

  localparam int W_OUT   = 2;
  localparam int NUM_VEC = 16;
`ifdef Q3_CHK_HALT_ON_FAIL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  q3_resp_checker_if #(.W_OUT(W_OUT), .CNT_W(5)) a_if ();
  q3_resp_checker_if #(.W_OUT(W_OUT), .CNT_W(2)) b_if ();

  assign b_if.start     = a_if.start;
  assign b_if.vec_valid = a_if.vec_valid;
  assign b_if.vec       = a_if.vec;
  assign b_if.dut_out   = a_if.dut_out;
  assign b_if.ref_out   = a_if.ref_out;

  q3_resp_checker #(.W_OUT(W_OUT), .NUM_VEC(NUM_VEC), .CNT_W(5)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  q3_resp_checker #(.W_OUT(W_OUT), .NUM_VEC(NUM_VEC), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  // Expected visible state just after edge number cyc.
  typedef struct {
    int       cyc;
    bit       busy;
    bit       done;
    bit       pass;
    int       err5;
    int       err2;
    bit [3:0] ffv;
    bit [1:0] ffm;
    bit       seq;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Sweep-level reference model: counts and first failure of accepted vectors.
  int       m_err;
  bit       m_seq;
  bit [3:0] m_ffv;
  bit [1:0] m_ffm;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit valid, input bit [3:0] v,
                       input bit [1:0] d, input bit [1:0] r);
    a_if.start     = s;
    a_if.vec_valid = valid;
    a_if.vec       = v;
    a_if.dut_out   = d;
    a_if.ref_out   = r;
  endtask

  task automatic model_clear();
    m_err = 0;
    m_seq = 1'b0;
    m_ffv = '0;
    m_ffm = '0;
  endtask

  task automatic push_snap(input bit busy, input bit done, input bit pass);
    exp_t e;
    e.cyc  = cyc + 1;
    e.busy = busy;
    e.done = done;
    e.pass = pass;
    e.err5 = (m_err > 31) ? 31 : m_err;
    e.err2 = (m_err > 3) ? 3 : m_err;
    e.ffv  = m_ffv;
    e.ffm  = m_ffm;
    e.seq  = m_seq;
    sb.push_back(e);
  endtask

  // Monitor: compares both instances whenever an expected snapshot is due.
  bit done_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("missed_snapshot", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("busy",            int'(a_if.busy),            int'(e.busy));
      check("done",            int'(a_if.done),            int'(e.done));
      check("pass",            int'(a_if.pass),            int'(e.pass));
      check("err_count",       int'(a_if.err_count),       e.err5);
      check("first_fail_vec",  int'(a_if.first_fail_vec),  int'(e.ffv));
      check("first_fail_mask", int'(a_if.first_fail_mask), int'(e.ffm));
      check("seq_err",         int'(a_if.seq_err),         int'(e.seq));
      check("sat_done",        int'(b_if.done),            int'(e.done));
      check("sat_pass",        int'(b_if.pass),            int'(e.pass));
      check("sat_err_count",   int'(b_if.err_count),       e.err2);
      check("sat_first_fail",  int'(b_if.first_fail_vec),  int'(e.ffv));
    end else if (a_if.done && !done_q) begin
      check("unexpected_done_rise", int'(a_if.done), int'(done_q));
    end
    done_q = a_if.done;
  end

  task automatic begin_sweep();
    model_clear();
    // A vector presented together with start must be discarded.
    drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 2'b01, 2'b10);
    push_snap(1'b1, 1'b0, 1'b0);
    tick();
  endtask

  // kind: 0 clean, 1 single fault, 2 order violation, 3 gapped,
  //       4 reset after 7 vectors, 5 all mismatching, 6 random
  task automatic sweep(input int kind);
    bit [3:0] v;
    bit [1:0] d, r;
    bit       mm, last;
    begin_sweep();
    for (int i = 0; i < NUM_VEC; i++) begin
      if (kind == 3 || (kind == 6 && $urandom_range(0, 3) == 0)) begin
        drive(1'b0, 1'b0, 4'($urandom), 2'($urandom), 2'($urandom));
        tick();
      end
      v = 4'(i);
      d = 2'($urandom);
      r = d;
      case (kind)
        1: if (i == 3) begin d = 2'b10; r = 2'b11; end
        2: if (i >= 3) v = 4'(i + 1);
        4: if (i == 2 || i == 5) r = ~d;
        5: r = ~d;
        6: begin
          if ($urandom_range(0, 3) == 0) r = 2'($urandom);
          if ($urandom_range(0, 15) == 0) v = 4'($urandom);
        end
        default: ;
      endcase
      if (kind == 4 && i == 7) begin
        rst = 1'b1;
        drive(1'b1, 1'b1, v, d, ~d);
        model_clear();
        push_snap(1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 2'b00, 2'b00);
        return;
      end
      mm = (d != r);
      if (mm) begin
        if (m_err == 0) begin
          m_ffv = v;
          m_ffm = d ^ r;
        end
        m_err++;
      end
      if (v != 4'(i)) m_seq = 1'b1;
      last = (i == NUM_VEC - 1) || (HALT && mm);
      push_snap(!last, last, last && m_err == 0 && !m_seq);
      drive(1'b0, 1'b1, v, d, r);
      tick();
      if (last) break;
    end
    // DONE must ignore further mismatching vectors.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 4'($urandom), 2'b01, 2'b10);
      push_snap(1'b0, 1'b1, m_err == 0 && !m_seq);
      tick();
    end
    drive(1'b0, 1'b0, 4'h0, 2'b00, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 2'b00, 2'b00);
    model_clear();
    tick();
    // start alongside rst: reset wins
    drive(1'b1, 1'b1, 4'h0, 2'b01, 2'b10);
    push_snap(1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 2'b00, 2'b00);
    tick();

    sweep(0);
    sweep(1);
    sweep(2);
    sweep(3);
    sweep(4);
    sweep(0);
    sweep(5);
    for (int n = 0; n < 20; n++) sweep(6);
    sweep(0);

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
